// File: rtl/score_keeper.sv
// score_keeper: two-player score tracking and match state machine (idle/play/serve-hold/game-over).
// Optional SCORE_SEG_EN adds registered active-low seven-segment score outputs.
`default_nettype none

module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 25000000,
  parameter int START       = 103,
  parameter int RESTART     = 98
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic [7:0] i_key_byte,
  input  logic       i_p1_scored,
  input  logic       i_p2_scored,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic       o_point_pulse,
  output logic       o_serve_hold,
  output logic       o_game_over,
  output logic [1:0] o_winner
`ifdef SCORE_SEG_EN
  ,
  output logic [6:0] o_p1_seg,
  output logic [6:0] o_p2_seg
`endif
);

  localparam int              CW          = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0]   HOLD_LOAD   = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]      WIN_VAL     = 4'(WIN_SCORE);
  localparam logic [7:0]      START_KEY   = 8'(START);
  localparam logic [7:0]      RESTART_KEY = 8'(RESTART);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PLAY       = 2'd1,
    S_POINT_HOLD = 2'd2,
    S_GAME_OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    p1_q, p1_d, p2_q, p2_d;
  logic [1:0]    winner_q, winner_d;
  logic          pulse_q, pulse_d, hold_q, hold_d, over_q, over_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p1_prev_q, p2_prev_q;
  logic [7:0]    key_prev_q;

  logic       start_ev, restart_ev, p1_ev, p2_ev;
  logic [3:0] new_score;

  assign start_ev   = (i_key_byte == START_KEY)   && (key_prev_q != START_KEY);
  assign restart_ev = (i_key_byte == RESTART_KEY) && (key_prev_q != RESTART_KEY);
  assign p1_ev      = i_p1_scored & ~p1_prev_q;
  assign p2_ev      = i_p2_scored & ~p2_prev_q;

  always_comb begin
    state_d   = state_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    new_score = p1_ev ? (p1_q + 4'd1) : (p2_q + 4'd1);

    case (state_q)
      S_IDLE: begin
        p1_d     = 4'd0;
        p2_d     = 4'd0;
        winner_d = 2'b00;
        if (start_ev) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Simultaneous edges cancel: neither player is credited.
        if (p1_ev ^ p2_ev) begin
          pulse_d = 1'b1;
          if (p1_ev) p1_d = new_score;
          else       p2_d = new_score;
          if (new_score == WIN_VAL) begin
            state_d  = S_GAME_OVER;
            winner_d = p1_ev ? 2'b01 : 2'b10;
          end else begin
            state_d = S_POINT_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      S_POINT_HOLD: begin
        if (cnt_q == '0) state_d = S_PLAY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_GAME_OVER: begin
        if (start_ev) begin
          state_d  = S_PLAY;
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          winner_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart_ev) begin
      state_d  = S_IDLE;
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      winner_d = 2'b00;
      cnt_d    = '0;
      pulse_d  = 1'b0;
    end

    hold_d = (state_d == S_POINT_HOLD);
    over_d = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= S_IDLE;
      p1_q       <= 4'd0;
      p2_q       <= 4'd0;
      winner_q   <= 2'b00;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      hold_q     <= 1'b0;
      over_q     <= 1'b0;
      p1_prev_q  <= 1'b0;
      p2_prev_q  <= 1'b0;
      key_prev_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      winner_q   <= winner_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      hold_q     <= hold_d;
      over_q     <= over_d;
      p1_prev_q  <= i_p1_scored;
      p2_prev_q  <= i_p2_scored;
      key_prev_q <= i_key_byte;
    end
  end

  assign o_p1_score    = p1_q;
  assign o_p2_score    = p2_q;
  assign o_point_pulse = pulse_q;
  assign o_serve_hold  = hold_q;
  assign o_game_over   = over_q;
  assign o_winner      = winner_q;

`ifdef SCORE_SEG_EN
  // Active-low {g,f,e,d,c,b,a}; hex letters beyond 9.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [6:0] p1_seg_q, p2_seg_q;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      p1_seg_q <= 7'b1000000;
      p2_seg_q <= 7'b1000000;
    end else begin
      p1_seg_q <= seg7(p1_d);
      p2_seg_q <= seg7(p2_d);
    end
  end

  assign o_p1_seg = p1_seg_q;
  assign o_p2_seg = p2_seg_q;
`endif

endmodule

`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Receives the per-player scored indications from the ball engine and tracks both players' scores. Runs the match-level state machine: waiting for start, active rally, post-point serve hold, and game over. Sits between the ball engine and the display/text overlay. Outputs current scores, a serve-hold level that gates the next serve, and the winner.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..15.
SERVE_DELAY, 25000000, POINT_HOLD duration in i_CLK cycles (1 s at 25 MHz); >=1.
START, 103, ASCII start key ('g').
RESTART, 98, ASCII restart key ('b').

Ports:
i_CLK  in  1  system clock
i_RST_N  in  1  asynchronous active-low reset
i_key_byte  in  8  last ASCII byte from keyboard path; held until next key
i_p1_scored  in  1  P1 scored indication; rising edge = one point
i_p2_scored  in  1  P2 scored indication; rising edge = one point
o_p1_score  out  4  P1 score, binary
o_p2_score  out  4  P2 score, binary
o_point_pulse  out  1  one-cycle strobe when any score increments
o_serve_hold  out  1  high while in POINT_HOLD
o_game_over  out  1  high while in GAME_OVER
o_winner  out  2  00 none, 01 P1, 10 P2; valid while o_game_over

Behaviour:
- Async reset (i_RST_N low): state IDLE; scores 0; o_point_pulse, o_serve_hold, o_game_over 0; o_winner 00; serve counter 0; edge/key history regs 0. All outputs are registered.
- Edge detect: previous i_pN_scored is registered each cycle. A point event is input high and previous low.
- Key detect: previous i_key_byte is registered each cycle. A key event requires i_key_byte == K and previous != K, so a held key fires once.
- Both point edges in the same cycle: neither is counted, state is unchanged, no pulse.
- States are IDLE, PLAY, POINT_HOLD, GAME_OVER. A RESTART event in any state goes to IDLE next cycle and takes priority over every other event.
- IDLE: scores held at 0; o_winner 00. A START event goes to PLAY.
- PLAY, point edge at cycle N: the score is incremented at edge N+1 and o_point_pulse is high for that cycle.
  - If the new score == WIN_SCORE: go to GAME_OVER; o_winner = 01 (P1) or 10 (P2); o_game_over high from N+1.
  - Otherwise: go to POINT_HOLD; o_serve_hold high from N+1; counter loaded with SERVE_DELAY-1.
- POINT_HOLD: counter decrements once per cycle. When it reaches 0, return to PLAY next cycle. o_serve_hold is high for exactly SERVE_DELAY cycles. Point edges in this state are ignored (history regs still update).
- GAME_OVER: scores and o_winner frozen; point edges ignored. A START event clears scores and o_winner and goes to PLAY.
- Score arithmetic is 4-bit; WIN_SCORE <= 15 guarantees no wrap.
- Reset asserted mid-hold or mid-game: immediate return to reset values; the partial counter is discarded.

Optional Feature:
SCORE_SEG_EN
- Defined: adds ports o_p1_seg and o_p2_seg (out, 7 bits each). These are active-low seven-segment codes {g,f,e,d,c,b,a} for each score, digits 0-9, hex A-F beyond 9. They are registered, update in the same cycle as o_pN_score, and reset to the code for 0 (7'b1000000).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
(All scenarios use WIN_SCORE=3, SERVE_DELAY=4 unless noted.)
1. Reset, then START key event, then a P1 rising edge: state PLAY; next cycle o_p1_score=1 and o_point_pulse high for 1 cycle; o_serve_hold high for exactly 4 cycles, then PLAY.
2. P1 held high through POINT_HOLD, then a fresh P2 edge in PLAY: P1 not double-counted; o_p2_score=1.
3. P2 scores 3 points (each after its hold): o_game_over=1, o_winner=10 on the cycle o_p2_score becomes 3; further edges leave 0/3 unchanged.
4. Both scored inputs rise in the same cycle during PLAY: scores unchanged, no o_point_pulse, state stays PLAY.
5. RESTART event during POINT_HOLD at score 2/1: next cycle IDLE, scores 0/0, o_serve_hold 0. START held for 10 cycles: exactly one transition to PLAY.
6. Reset asserted in GAME_OVER: all outputs 0 immediately. With SCORE_SEG_EN defined, o_p1_seg=7'b1000000 after reset and 7'b1111001 after the first P1 point.
